p2s_shifter: RTL

Parallel-in/serial-out transmitter. It accepts a WIDTH-bit word through a valid/ready handshake and emits it MSB-first on a serial line, one bit per enabled cycle. It also emits a per-bit strobe. The block is the sending end of the team's serial-in shift receiver: wire `sout` to the receiver's serial input and `bit_en` to its enable. After WIDTH strobed cycles, the receiver's parallel register holds the transmitted word unchanged.

---
 rtl/p2s_shifter.sv | 63 ++++++
 1 files changed

// File: rtl/p2s_shifter.sv
// Parallel-in/serial-out transmitter: MSB first, one bit per non-stalled cycle, done pulse after the last bit.
// Latency: first bit in the cycle after acceptance. Backpressure: ready only in IDLE, and stall freezes shifting.
module p2s_shifter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             stall,
   output logic             ready,
   output logic             sout,
   output logic             bit_en,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  shreg <= din;
                  cnt   <= CW'(WIDTH);
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               // A stalled cycle holds everything, so the current bit is simply repeated.
               if (!stall) begin
                  shreg <= {shreg[WIDTH-2:0], 1'b0};
                  cnt   <= cnt - CW'(1);
                  if (cnt == CW'(1)) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ready  = (state == IDLE);
   assign busy   = (state == SHIFT);
   assign sout   = shreg[WIDTH-1];
   assign bit_en = (state == SHIFT) && !stall;

endmodule
